cmd_receiver_dd: RTL and testbench



---
 rtl/cmd_receiver_dd_pkg.sv | 20 ++
 rtl/cmd_deframer.sv | 148 ++++++++++++++
 rtl/cmd_receiver_dd.sv | 77 +++++++
 tb/tb_cmd_receiver_dd.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_receiver_dd_pkg.sv
// Shared definitions for the control command link (transmitter and receiver).
package cmd_receiver_dd_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam bit PAR_ODD_DEF  = 1'b1;
    localparam int MIN_IDLE_DEF = 2;
    localparam int ERRCNT_W_DEF = 8;

    // start + payload + parity + stop
    localparam int FRAME_LEN    = DATA_W_DEF + 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DATA  = 3'd1,
        ST_PAR   = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/cmd_deframer.sv
// Serial command deframer: input register, start/data/parity/stop FSM,
// shift register and parity check. Result pulses are registered.
//
// state    | meaning
// ST_IDLE  | counting idle '1' bits, waiting for a qualified start bit
// ST_DATA  | shifting in payload bits, MSB first
// ST_PAR   | capturing the parity bit
// ST_STOP  | checking stop bit and parity, issuing result pulse
// ST_BREAK | line held low after a framing error, waiting for '1'
module cmd_deframer
    import cmd_receiver_dd_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit PAR_ODD  = PAR_ODD_DEF,
    parameter int MIN_IDLE = MIN_IDLE_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              i_rx,
    output logic [DATA_W-1:0] o_data,
    output logic              o_good,
    output logic              o_perr,
    output logic              o_ferr
);

    localparam int IDLE_W = $clog2(MIN_IDLE + 1);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(MIN_IDLE);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

    rx_state_t          r_state;
    logic               r_d_q;
    logic [IDLE_W-1:0]  r_idle_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shreg;
    logic               r_par;
    logic               r_good;
    logic               r_perr;
    logic               r_ferr;

    rx_state_t          w_state_nxt;
    logic [IDLE_W-1:0]  w_idle_nxt;
    logic [BIT_W-1:0]   w_bit_nxt;
    logic [DATA_W-1:0]  w_shreg_nxt;
    logic               w_par_nxt;
    logic               w_good_nxt;
    logic               w_perr_nxt;
    logic               w_ferr_nxt;
    logic               w_par_ok;

    // State and datapath registers; reset aborts any frame in flight silently.
    always_ff @(posedge clk) begin
        if (res) begin
            r_d_q      <= 1'b1;
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_par      <= 1'b0;
            r_good     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_d_q      <= i_rx;
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
            r_par      <= w_par_nxt;
            r_good     <= w_good_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    // Next-state, shift/parity capture and result pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idle_nxt  = r_idle_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_par_nxt   = r_par;
        w_good_nxt  = 1'b0;
        w_perr_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_par_ok    = (((^r_shreg) ^ r_par) == PAR_ODD);

        case (r_state)
            ST_IDLE: begin
                if (r_d_q) begin
                    if (r_idle_cnt != IDLE_MAX) begin
                        w_idle_nxt = r_idle_cnt + 1'b1;
                    end
                end else if (r_idle_cnt == IDLE_MAX) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                end else begin
                    // start too soon after activity: treat as a glitch
                    w_idle_nxt = '0;
                end
            end
            ST_DATA: begin
                w_shreg_nxt = {r_shreg[DATA_W-2:0], r_d_q};
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt = ST_PAR;
                end else begin
                    w_bit_nxt = r_bit_cnt + 1'b1;
                end
            end
            ST_PAR: begin
                w_par_nxt   = r_d_q;
                w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (r_d_q) begin
                    // stop bit doubles as the first idle bit
                    w_state_nxt = ST_IDLE;
                    w_idle_nxt  = IDLE_ONE;
                    if (w_par_ok) begin
                        w_good_nxt = 1'b1;
                    end else begin
                        w_perr_nxt = 1'b1;
                    end
                end else begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (r_d_q) begin
                    w_state_nxt = ST_IDLE;
                    w_idle_nxt  = IDLE_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idle_nxt  = '0;
            end
        endcase
    end

    assign o_data = r_shreg;
    assign o_good = r_good;
    assign o_perr = r_perr;
    assign o_ferr = r_ferr;

endmodule

// File: rtl/cmd_receiver_dd.sv
// Command link receiver top: deframer, one-entry valid/ready output
// register, error pulses and saturating error counter.
module cmd_receiver_dd
    import cmd_receiver_dd_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter bit PAR_ODD  = PAR_ODD_DEF,
    parameter int MIN_IDLE = MIN_IDLE_DEF,
    parameter int ERRCNT_W = ERRCNT_W_DEF
) (
    input  logic                clk,
    input  logic                res,
    input  logic                d_rs,
    output logic [DATA_W-1:0]   dout,
    output logic                validout,
    input  logic                readyin,
    output logic                perr,
    output logic                ferr,
    output logic                ovr,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic [DATA_W-1:0] w_data;
    logic              w_good;
    logic              w_perr;
    logic              w_ferr;

    cmd_deframer #(
        .DATA_W   (DATA_W),
        .PAR_ODD  (PAR_ODD),
        .MIN_IDLE (MIN_IDLE)
    ) u_deframer (
        .clk    (clk),
        .res    (res),
        .i_rx   (d_rs),
        .o_data (w_data),
        .o_good (w_good),
        .o_perr (w_perr),
        .o_ferr (w_ferr)
    );

    // Output register: load when empty or being drained, else drop the frame.
    always_ff @(posedge clk) begin
        if (res) begin
            dout     <= '0;
            validout <= 1'b0;
        end else if (w_good && (!validout || readyin)) begin
            dout     <= w_data;
            validout <= 1'b1;
        end else if (readyin) begin
            validout <= 1'b0;
        end
    end

    // Error pulses aligned with the cycle a delivery would have happened.
    always_ff @(posedge clk) begin
        if (res) begin
            perr <= 1'b0;
            ferr <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            perr <= w_perr;
            ferr <= w_ferr;
            ovr  <= w_good & validout & ~readyin;
        end
    end

    // Saturating count of error pulse cycles.
    always_ff @(posedge clk) begin
        if (res) begin
            err_cnt <= '0;
        end else if ((perr || ferr || ovr) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_receiver_dd.sv
// Self-checking bench for cmd_receiver_dd: frame table, hand-written
// corner sequences and randomized frames against a cycle scoreboard.
module tb_cmd_receiver_dd;

    localparam int K_GOOD = 0;
    localparam int K_PERR = 1;
    localparam int K_FERR = 2;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        d_rs = 1'b1;
    logic        readyin = 1'b0;
    logic [31:0] dout;
    logic        validout;
    logic        perr;
    logic        ferr;
    logic        ovr;
    logic [7:0]  err_cnt;

    cmd_receiver_dd dut (
        .clk      (clk),
        .res      (res),
        .d_rs     (d_rs),
        .dout     (dout),
        .validout (validout),
        .readyin  (readyin),
        .perr     (perr),
        .ferr     (ferr),
        .ovr      (ovr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] data;
    } ev_t;
    ev_t evq[$];

    // ---------------- scoreboard model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_dout  = '0;
    int          m_cnt   = 0;
    logic        m_pend  = 1'b0;
    logic        res_prev = 1'b1;
    logic        rdy_prev = 1'b0;
    int          sb_prints = 0;

    always @(negedge clk) begin
        logic e_perr, e_ferr, e_ovr;
        ev_t  ev;
        e_perr = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
        if (res_prev) begin
            m_valid = 1'b0; m_dout = '0; m_cnt = 0; m_pend = 1'b0;
        end else begin
            if (m_pend && m_cnt != 255) m_cnt++;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (ev.kind == K_GOOD) begin
                    if (!m_valid || rdy_prev) begin
                        m_dout  = ev.data;
                        m_valid = 1'b1;
                    end else begin
                        e_ovr = 1'b1;
                    end
                end else if (ev.kind == K_PERR) begin
                    e_perr = 1'b1;
                    if (rdy_prev) m_valid = 1'b0;
                end else begin
                    e_ferr = 1'b1;
                    if (rdy_prev) m_valid = 1'b0;
                end
            end else if (rdy_prev) begin
                m_valid = 1'b0;
            end
            m_pend = e_perr | e_ferr | e_ovr;
        end
        n_cmp++;
        if (dout !== m_dout || validout !== m_valid || perr !== e_perr ||
            ferr !== e_ferr || ovr !== e_ovr || err_cnt !== 8'(m_cnt)) begin
            n_fail++;
            if (sb_prints < 20) begin
                sb_prints++;
                $display("FAIL sb cyc=%0d dout=%h want %h valid=%b want %b perr=%b want %b ferr=%b want %b ovr=%b want %b cnt=%0d want %0d",
                         cyc, dout, m_dout, validout, m_valid, perr, e_perr,
                         ferr, e_ferr, ovr, e_ovr, err_cnt, m_cnt);
            end
        end
        res_prev = res;
        rdy_prev = readyin;
    end

    // ---------------- driver ----------------
    logic rnd_rdy = 1'b0;

    task automatic step(input logic b);
        d_rs = b;
        if (rnd_rdy) readyin = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic send_frame(input logic [31:0] data, input logic p,
                              input logic stop, input int kind, input bit sched);
        ev_t ev;
        step(1'b0);
        for (int i = 31; i >= 0; i--) step(data[i]);
        step(p);
        ev.cyc  = cyc + 3;
        ev.kind = kind;
        ev.data = data;
        if (sched) evq.push_back(ev);
        step(stop);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        par;
        logic        stop;
        int          kind;
        int          low_after;
    } vec_t;

    initial begin
        vec_t        tbl[7];
        int          n_err_tbl;
        logic [31:0] rd;
        logic        rp, rs;
        int          rk, sel;

        tbl[0] = '{32'h55AA_1234, 1'b0, 1'b1, K_GOOD, 0};
        tbl[1] = '{32'h0000_0001, 1'b1, 1'b1, K_PERR, 0};
        tbl[2] = '{32'hFFFF_FFFF, 1'b1, 1'b0, K_FERR, 5};
        tbl[3] = '{32'h0000_00A5, 1'b1, 1'b1, K_GOOD, 0};
        tbl[4] = '{32'h8000_0000, 1'b0, 1'b1, K_GOOD, 0};
        tbl[5] = '{32'h0000_0000, 1'b1, 1'b1, K_GOOD, 0};
        tbl[6] = '{32'h0000_0000, 1'b0, 1'b1, K_PERR, 0};

        res = 1'b1; d_rs = 1'b1; readyin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, validout}, 32'd0);
        chk("reset_dout", dout, 32'd0);
        chk("reset_errcnt", {24'd0, err_cnt}, 32'd0);
        res = 1'b0;
        readyin = 1'b1;
        idle(4);

        // table of single frames
        n_err_tbl = 0;
        for (int i = 0; i < 7; i++) begin
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].kind, 1'b1);
            for (int j = 0; j < tbl[i].low_after; j++) step(1'b0);
            idle(3);
            if (tbl[i].kind != K_GOOD) n_err_tbl++;
        end
        idle(2);
        chk("tbl_errcnt", {24'd0, err_cnt}, 32'(n_err_tbl));

        // start immediately after stop is a glitch; next frame still lands
        send_frame(32'h8000_0000, 1'b0, 1'b1, K_GOOD, 1'b1);
        step(1'b0);
        idle(3);
        send_frame(32'h0000_000A, 1'b1, 1'b1, K_GOOD, 1'b1);
        idle(4);
        chk("glitch_dout", dout, 32'h0000_000A);

        // overrun: second frame dropped while first is held
        readyin = 1'b0;
        send_frame(32'h1111_1111, 1'b1, 1'b1, K_GOOD, 1'b1);
        idle(3);
        send_frame(32'h2222_2222, 1'b1, 1'b1, K_GOOD, 1'b1);
        idle(3);
        chk("ovr_dout", dout, 32'h1111_1111);
        chk("ovr_valid", {31'd0, validout}, 32'd1);
        chk("ovr_errcnt", {24'd0, err_cnt}, 32'(n_err_tbl + 1));
        readyin = 1'b1;
        step(1'b1);
        chk("ovr_drain", {31'd0, validout}, 32'd0);
        idle(2);

        // accept and load in the same cycle
        readyin = 1'b0;
        send_frame(32'h0000_000A, 1'b1, 1'b1, K_GOOD, 1'b1);
        idle(3);
        send_frame(32'h0000_000B, 1'b0, 1'b1, K_GOOD, 1'b1);
        step(1'b1);
        readyin = 1'b1;
        step(1'b1);
        readyin = 1'b0;
        chk("simul_dout", dout, 32'h0000_000B);
        chk("simul_valid", {31'd0, validout}, 32'd1);
        chk("simul_ovr", {31'd0, ovr}, 32'd0);
        readyin = 1'b1;
        idle(3);

        // reset in the middle of a frame
        step(1'b0);
        for (int i = 31; i >= 22; i--) step(rd_const(i));
        res = 1'b1;
        idle(2);
        res = 1'b0;
        idle(3);
        chk("rst_errcnt", {24'd0, err_cnt}, 32'd0);
        send_frame(32'hDEAD_BEEF, 1'b1, 1'b1, K_GOOD, 1'b1);
        idle(4);
        chk("rst_dout", dout, 32'hDEAD_BEEF);
        chk("rst_errcnt2", {24'd0, err_cnt}, 32'd0);

        // randomized frames with random consumer back-pressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            rd  = $urandom;
            sel = $urandom_range(0, 11);
            rp  = ~(^rd);
            rs  = 1'b1;
            if (sel < 2) rp = ~rp;
            if (sel == 2) rs = 1'b0;
            if (!rs) rk = K_FERR;
            else if (((^rd) ^ rp) == 1'b1) rk = K_GOOD;
            else rk = K_PERR;
            send_frame(rd, rp, rs, rk, 1'b1);
            if (!rs) begin
                for (int j = 0; j < int'($urandom_range(0, 4)); j++) step(1'b0);
                idle(int'($urandom_range(2, 4)));
            end else begin
                idle(int'($urandom_range(1, 4)));
            end
        end
        rnd_rdy = 1'b0;
        readyin = 1'b1;
        idle(4);

        // counter saturation
        for (int n = 0; n < 300; n++) begin
            rd = $urandom;
            send_frame(rd, ^rd, 1'b1, K_PERR, 1'b1);
            idle(1);
        end
        idle(4);
        chk("sat_errcnt", {24'd0, err_cnt}, 32'd255);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    function automatic logic rd_const(input int i);
        logic [31:0] v;
        v = 32'h1234_5678;
        return v[i];
    endfunction

endmodule
